// File: rtl/pc_gen_pkg.sv
// Shared types, default constants and offset helper for the IF-stage PC generator.
package pc_gen_pkg;

  typedef enum logic [1:0] {
    PC_RUN   = 2'd0,
    PC_HALT  = 2'd1,
    PC_FAULT = 2'd2
  } pc_state_e;

  // Widest PC the offset helper can handle; XLEN must not exceed this.
  localparam int unsigned PC_MAX_W = 128;

  localparam logic [63:0] DEF_RESET_PC   = 64'h0;
  localparam logic [63:0] DEF_PC_LIMIT   = 64'h200;
  localparam int unsigned DEF_INST_BYTES = 4;

  // The caller sign-extends with a signed size cast; this applies the branch scaling.
  function automatic logic [PC_MAX_W-1:0] offset_sext_shl(input logic [PC_MAX_W-1:0] off_ext,
                                                          input int unsigned       shamt);
    return off_ext << shamt;
  endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection: jump > taken branch > sequential, plus fault/limit flags.
module pc_next_calc
  import pc_gen_pkg::*;
#(
  parameter int unsigned       XLEN       = 64,
  parameter logic [XLEN-1:0]   PC_LIMIT   = XLEN'(DEF_PC_LIMIT),
  parameter int unsigned       INST_BYTES = DEF_INST_BYTES,
  parameter int unsigned       BR_SHIFT   = 1
)(
  input  logic [XLEN-1:0] pc_i,
  input  logic            branch_i,
  input  logic            alu_zero_i,
  input  logic [XLEN-1:0] branch_offset_i,
  input  logic            jump_i,
  input  logic [XLEN-1:0] jump_target_i,
  output logic [XLEN-1:0] candidate_o,
  output logic            is_redirect_o,
  output logic            misaligned_o,
  output logic            over_limit_o
);

  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INST_BYTES - 1);

  logic [PC_MAX_W-1:0] br_delta_w;
  logic [XLEN-1:0]     br_target;
  logic [XLEN-1:0]     seq_target;

  assign br_delta_w = offset_sext_shl(PC_MAX_W'($signed(branch_offset_i)), BR_SHIFT);
  assign br_target  = pc_i + br_delta_w[XLEN-1:0];
  assign seq_target = pc_i + XLEN'(INST_BYTES);

  always_comb begin
    // NOTE: every output gets a default first so no path through this block infers a latch.
    candidate_o   = seq_target;
    is_redirect_o = 1'b0;
    if (jump_i) begin
      candidate_o   = jump_target_i;
      is_redirect_o = 1'b1;
    end else if (branch_i && alu_zero_i) begin
      candidate_o   = br_target;
      is_redirect_o = 1'b1;
    end
  end

  // Wrapped negative targets land far above the limit and are caught here.
  assign misaligned_o = |(candidate_o & ALIGN_MASK);
  assign over_limit_o = (candidate_o >= PC_LIMIT);

endmodule

// File: rtl/pc_gen_unit.sv
// IF-stage program counter with RUN/HALT/FAULT control, redirect flag and advance counter.
module pc_gen_unit
  import pc_gen_pkg::*;
#(
  parameter int unsigned     XLEN       = 64,
  parameter logic [XLEN-1:0] RESET_PC   = XLEN'(DEF_RESET_PC),
  parameter logic [XLEN-1:0] PC_LIMIT   = XLEN'(DEF_PC_LIMIT),
  parameter int unsigned     INST_BYTES = DEF_INST_BYTES,
  parameter int unsigned     BR_SHIFT   = 1,
  parameter int unsigned     CNT_W      = 32
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             pc_write,
  input  logic             branch,
  input  logic             alu_zero,
  input  logic [XLEN-1:0]  branch_offset,
  input  logic             jump,
  input  logic [XLEN-1:0]  jump_target,
  input  logic             resume,
  output logic [XLEN-1:0]  pc_out,
  output logic [XLEN-1:0]  pc_next_seq,
  output logic             redirect,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] adv_count
);

  pc_state_e        state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             redirect_q, redirect_d;

  logic [XLEN-1:0]  candidate;
  logic             is_redirect;
  logic             misaligned;
  logic             over_limit;
  logic             advance;
  logic             do_resume;

  pc_next_calc #(
    .XLEN       (XLEN),
    .PC_LIMIT   (PC_LIMIT),
    .INST_BYTES (INST_BYTES),
    .BR_SHIFT   (BR_SHIFT)
  ) u_next (
    .pc_i            (pc_q),
    .branch_i        (branch),
    .alu_zero_i      (alu_zero),
    .branch_offset_i (branch_offset),
    .jump_i          (jump),
    .jump_target_i   (jump_target),
    .candidate_o     (candidate),
    .is_redirect_o   (is_redirect),
    .misaligned_o    (misaligned),
    .over_limit_o    (over_limit)
  );

  assign advance   = (state_q == PC_RUN) && pc_write && !misaligned && !over_limit;
  assign do_resume = (state_q != PC_RUN) && resume;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= PC_RUN;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      PC_RUN: begin
        if (pc_write) begin
          if (misaligned)      state_d = PC_FAULT;
          else if (over_limit) state_d = PC_HALT;
        end
      end
      PC_HALT, PC_FAULT: begin
        if (resume) state_d = PC_RUN;
      end
      default: state_d = PC_RUN;
    endcase
  end

  // A stall or a stopped state leaves PC and count alone and always clears redirect.
  always_comb begin
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    redirect_d = 1'b0;
    if (advance) begin
      pc_d       = candidate;
      cnt_d      = cnt_q + CNT_W'(1);
      redirect_d = is_redirect;
    end else if (do_resume) begin
      pc_d  = RESET_PC;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q       <= RESET_PC;
      cnt_q      <= '0;
      redirect_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      redirect_q <= redirect_d;
    end
  end

  always_comb begin
    pc_out      = pc_q;
    pc_next_seq = pc_q + XLEN'(INST_BYTES);
    redirect    = redirect_q;
    adv_count   = cnt_q;
    halted      = (state_q == PC_HALT);
    fault       = (state_q == PC_FAULT);
  end

endmodule

// File: tb/tb_pc_gen_unit.sv
// Scoreboard bench for pc_gen_unit: directed test-plan walk, then randomized traffic vs a reference model.
module tb_pc_gen_unit;

  localparam logic [63:0] T_RESET_PC = 64'h0;
  localparam logic [63:0] T_LIMIT    = 64'h200;
  localparam int          M_RUN      = 0;
  localparam int          M_HALT     = 1;
  localparam int          M_FAULT    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_write, branch, alu_zero, jump, resume;
  logic [63:0] branch_offset, jump_target;
  logic [63:0] pc_out, pc_next_seq;
  logic        redirect, halted, fault;
  logic [31:0] adv_count;

  pc_gen_unit #(
    .XLEN       (64),
    .RESET_PC   (T_RESET_PC),
    .PC_LIMIT   (T_LIMIT),
    .INST_BYTES (4),
    .BR_SHIFT   (1),
    .CNT_W      (32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_write      (pc_write),
    .branch        (branch),
    .alu_zero      (alu_zero),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_target   (jump_target),
    .resume        (resume),
    .pc_out        (pc_out),
    .pc_next_seq   (pc_next_seq),
    .redirect      (redirect),
    .halted        (halted),
    .fault         (fault),
    .adv_count     (adv_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic [63:0] seq;
    logic        redir;
    logic        halt;
    logic        flt;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: architectural PC, count and mode.
  logic [63:0] m_pc   = T_RESET_PC;
  logic [31:0] m_cnt  = 32'd0;
  int          m_mode = M_RUN;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle has an observable output, so pop one expectation per falling edge.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      check("pc_out",      pc_out,           mon_e.pc);
      check("pc_next_seq", pc_next_seq,      mon_e.seq);
      check("redirect",    64'(redirect),    64'(mon_e.redir));
      check("halted",      64'(halted),      64'(mon_e.halt));
      check("fault",       64'(fault),       64'(mon_e.flt));
      check("adv_count",   64'(adv_count),   64'(mon_e.cnt));
    end
  end

  // Drive one cycle of inputs, advance the model at the edge and queue the expected outputs.
  task automatic step(input logic pw, input logic br, input logic z, input logic [63:0] off,
                      input logic j, input logic [63:0] jt, input logic res);
    logic [63:0] tgt;
    exp_t        e;
    logic        redir_exp;
    pc_write = pw; branch = br; alu_zero = z; branch_offset = off;
    jump = j; jump_target = jt; resume = res;
    @(posedge clk);
    redir_exp = 1'b0;
    if (m_mode != M_RUN) begin
      if (res) begin
        m_mode = M_RUN;
        m_pc   = T_RESET_PC;
        m_cnt  = 32'd0;
      end
    end else if (pw) begin
      if (j)            tgt = jt;
      else if (br && z) tgt = m_pc + off * 64'd2;
      else              tgt = m_pc + 64'd4;
      if ((tgt % 64'd4) != 64'd0) m_mode = M_FAULT;
      else if (tgt >= T_LIMIT)    m_mode = M_HALT;
      else begin
        m_pc      = tgt;
        m_cnt     = m_cnt + 32'd1;
        redir_exp = j || (br && z);
      end
    end
    e.pc    = m_pc;
    e.seq   = m_pc + 64'd4;
    e.redir = redir_exp;
    e.halt  = (m_mode == M_HALT);
    e.flt   = (m_mode == M_FAULT);
    e.cnt   = m_cnt;
    sb_q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  task automatic seq_step();
    step(1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0, 1'b0);
  endtask

  task automatic run_to(input logic [63:0] target);
    for (int i = 0; i < 300 && m_pc != target; i++) seq_step();
    if (m_pc != target) check("run_to_bound", m_pc, target);
  endtask

  // Reset is applied between edges and checked before any clock edge can occur.
  task automatic async_reset();
    rst = 1'b0;
    #1;
    check("rst_pc_out",   pc_out,          T_RESET_PC);
    check("rst_pc_seq",   pc_next_seq,     T_RESET_PC + 64'd4);
    check("rst_redirect", 64'(redirect),   64'd0);
    check("rst_halted",   64'(halted),     64'd0);
    check("rst_fault",    64'(fault),      64'd0);
    check("rst_count",    64'(adv_count),  64'd0);
    @(posedge clk);
    @(negedge clk);
    #1;
    rst    = 1'b1;
    m_pc   = T_RESET_PC;
    m_cnt  = 32'd0;
    m_mode = M_RUN;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] jt;
    logic [63:0] off;
    int          o;
    rst = 1'b1; pc_write = 1'b0; branch = 1'b0; alu_zero = 1'b0; jump = 1'b0; resume = 1'b0;
    branch_offset = '0; jump_target = '0;
    #2;
    async_reset();

    // Straight-line fetch: 0x0 .. 0x28
    for (int i = 0; i < 10; i++) seq_step();
    check("seq10_pc",  pc_out,         64'h28);
    check("seq10_cnt", 64'(adv_count), 64'd10);

    // Taken branch back by 16 bytes, then not-taken at the same PC
    run_to(64'h40);
    step(1'b1, 1'b1, 1'b1, -64'sd8, 1'b0, 64'd0, 1'b0);
    check("br_taken_pc",  pc_out,        64'h30);
    check("br_taken_red", 64'(redirect), 64'd1);
    run_to(64'h40);
    step(1'b1, 1'b1, 1'b0, -64'sd8, 1'b0, 64'd0, 1'b0);
    check("br_nt_pc",  pc_out,        64'h44);
    check("br_nt_red", 64'(redirect), 64'd0);

    // Program-limit halt, ignored redirect while halted, then resume
    step(1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0, 1'b1);
    run_to(64'h1fc);
    seq_step();
    check("halt_flag", 64'(halted), 64'd1);
    check("halt_pc",   pc_out,      64'h1fc);
    step(1'b1, 1'b0, 1'b0, 64'd0, 1'b1, 64'h40, 1'b0);
    step(1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0, 1'b1);
    check("resume_pc",  pc_out,         64'h0);
    check("resume_cnt", 64'(adv_count), 64'd0);
    check("resume_hlt", 64'(halted),    64'd0);

    // Misaligned jump faults; jump beats a taken branch
    step(1'b1, 1'b0, 1'b0, 64'd0, 1'b1, 64'h102, 1'b0);
    check("fault_flag", 64'(fault), 64'd1);
    check("fault_pc",   pc_out,     64'h0);
    step(1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 64'd4, 1'b1, 64'h80, 1'b0);
    check("jump_wins_pc", pc_out, 64'h80);

    // Stall with a taken branch held, then release
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 64'd8, 1'b0, 64'd0, 1'b0);
    check("stall_pc",  pc_out,         64'h80);
    check("stall_cnt", 64'(adv_count), 64'd1);
    check("stall_red", 64'(redirect),  64'd0);
    step(1'b1, 1'b1, 1'b1, 64'd8, 1'b0, 64'd0, 1'b0);
    check("release_pc",  pc_out,        64'h90);
    check("release_red", 64'(redirect), 64'd1);
    seq_step();

    // Asynchronous reset mid-stall and while faulted
    step(1'b0, 1'b1, 1'b1, 64'd8, 1'b0, 64'd0, 1'b0);
    async_reset();
    seq_step();
    step(1'b1, 1'b0, 1'b0, 64'd0, 1'b1, 64'h6, 1'b0);
    check("fault2_flag", 64'(fault), 64'd1);
    async_reset();

    // Randomized traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      o   = int'($urandom_range(0, 255)) - 128;
      off = 64'(o);
      jt  = 64'($urandom_range(0, 'h27f));
      if ($urandom_range(0, 3) != 0) jt[1:0] = 2'b00;
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
           off, $urandom_range(0, 9) == 0, jt, $urandom_range(0, 9) == 0);
    end

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
